// File: rtl/dmem_scan_reader_pkg.sv
// Shared types for the DMEM scan reader.
// Holds the 3-bit FSM state encoding used by the scanner and visible to benches.
package dmem_scan_reader_pkg;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StReq  = 3'd1,
        StWait = 3'd2,
        StHold = 3'd3,
        StDone = 3'd4
    } scan_state_e;

endpackage

// File: rtl/scan_dwell_timer.sv
// Dwell timer for the DMEM scan reader.
// Counts cycles spent holding a word and flags the last one, so the scanner can
// auto-advance. With DWELL=0 the expire output is constant 0 (step-only mode).
// Ports:
//   clk_i     system clock
//   rst_i     synchronous active-high reset
//   clear_i   restart the count (asserted the cycle before the hold is entered)
//   hold_i    scanner is holding a word; count advances while high
//   expire_o  hold has lasted DWELL cycles; advance at this edge
module scan_dwell_timer #(
    parameter int unsigned DWELL = 0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic hold_i,
    output logic expire_o
);

    localparam int unsigned CntWidth = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CntWidth-1:0] LastCnt = CntWidth'((DWELL == 0) ? 0 : DWELL - 1);

    logic [CntWidth-1:0] cnt_q;

    // Constant-false when DWELL=0, so the counter has no observable effect.
    assign expire_o = (DWELL != 0) && hold_i && (cnt_q == LastCnt);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (clear_i) begin
            cnt_q <= '0;
        end else if (hold_i && !expire_o) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/dmem_scan_reader.sv
// Read-only scanner for the data side of the unified dual-port BRAM.
// Walks a contiguous word window, presenting each address/word for display and
// accumulating a mod-2^DATA_WIDTH checksum. Never writes memory.
// Ports:
//   clk_i         system clock (shared with the BRAM port)
//   rst_i         synchronous active-high reset
//   start_i       one-cycle pulse: begin a scan (ignored while busy)
//   base_addr_i   first word address, latched on start
//   count_i       number of words, latched on start (saturated to 2^ADDR_WIDTH)
//   step_i        one-cycle pulse: advance to next word (only while holding)
//   mem_en_o      BRAM read enable
//   mem_addr_o    BRAM address
//   mem_dout_i    BRAM read data, valid one cycle after mem_en_o
//   cur_addr_o    address of cur_word_o
//   cur_word_o    last captured word
//   word_valid_o  cur_word_o/cur_addr_o valid (holding)
//   busy_o        scan in progress
//   done_o        scan finished; held until next start or reset
//   checksum_o    sum of words captured this scan
module dmem_scan_reader
    import dmem_scan_reader_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 9,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned DWELL      = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [ADDR_WIDTH:0]   count_i,
    input  logic                  step_i,
    output logic                  mem_en_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    input  logic [DATA_WIDTH-1:0] mem_dout_i,
    output logic [ADDR_WIDTH-1:0] cur_addr_o,
    output logic [DATA_WIDTH-1:0] cur_word_o,
    output logic                  word_valid_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] checksum_o
);

    // One full address space; larger counts would re-read addresses after wrap.
    localparam logic [ADDR_WIDTH:0] MaxCount = {1'b1, {ADDR_WIDTH{1'b0}}};

    scan_state_e           state_q;
    logic [ADDR_WIDTH-1:0] ptr_q;
    logic [ADDR_WIDTH:0]   rem_q;
    logic                  mem_en_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [ADDR_WIDTH-1:0] cur_addr_q;
    logic [DATA_WIDTH-1:0] cur_word_q;
    logic                  word_valid_q;
    logic                  busy_q;
    logic                  done_q;
    logic [DATA_WIDTH-1:0] checksum_q;

    logic [ADDR_WIDTH:0]   count_sat;
    logic [ADDR_WIDTH-1:0] ptr_next;
    logic                  dwell_expire;
    logic                  advance;

    always_comb begin
        count_sat = (count_i > MaxCount) ? MaxCount : count_i;
        ptr_next  = ptr_q + 1'b1;
        // step and dwell expiry together still produce a single advance.
        advance   = (state_q == StHold) && (step_i || dwell_expire);
    end

    scan_dwell_timer #(
        .DWELL(DWELL)
    ) u_dwell_timer (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (state_q == StWait),
        .hold_i  (state_q == StHold),
        .expire_o(dwell_expire)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            ptr_q        <= '0;
            rem_q        <= '0;
            mem_en_q     <= 1'b0;
            mem_addr_q   <= '0;
            cur_addr_q   <= '0;
            cur_word_q   <= '0;
            word_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            checksum_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (start_i) begin
                        ptr_q        <= base_addr_i;
                        rem_q        <= count_sat;
                        checksum_q   <= '0;
                        word_valid_q <= 1'b0;
                        if (count_sat == '0) begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q    <= StReq;
                            done_q     <= 1'b0;
                            busy_q     <= 1'b1;
                            mem_en_q   <= 1'b1;
                            mem_addr_q <= base_addr_i;
                        end
                    end
                end
                StReq: begin
                    // BRAM samples the request on this edge.
                    mem_en_q <= 1'b0;
                    state_q  <= StWait;
                end
                StWait: begin
                    cur_word_q   <= mem_dout_i;
                    cur_addr_q   <= ptr_q;
                    checksum_q   <= checksum_q + mem_dout_i;
                    rem_q        <= rem_q - 1'b1;
                    word_valid_q <= 1'b1;
                    state_q      <= StHold;
                end
                StHold: begin
                    if (advance) begin
                        word_valid_q <= 1'b0;
                        if (rem_q == '0) begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            ptr_q      <= ptr_next;
                            mem_en_q   <= 1'b1;
                            mem_addr_q <= ptr_next;
                            state_q    <= StReq;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign mem_en_o     = mem_en_q;
    assign mem_addr_o   = mem_addr_q;
    assign cur_addr_o   = cur_addr_q;
    assign cur_word_o   = cur_word_q;
    assign word_valid_o = word_valid_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign checksum_o   = checksum_q;

endmodule

// File: tb/tb_dmem_scan_reader.sv
// Directed bench for dmem_scan_reader: one instance in step mode (DWELL=0) and
// one in auto-advance mode (DWELL=4), each reading a BRAM preloaded with
// mem[i] = 16'h1000 + i. Inputs change and outputs are sampled on negedges.
module tb_dmem_scan_reader;
    import dmem_scan_reader_pkg::*;

    localparam int unsigned AW = 9;
    localparam int unsigned DW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          start_a;
    logic          start_b;
    logic          step_a;
    logic [AW-1:0] base;
    logic [AW:0]   count;

    logic          mem_en_a, mem_en_b;
    logic [AW-1:0] mem_addr_a, mem_addr_b;
    logic [DW-1:0] dout_a, dout_b;
    logic [AW-1:0] cur_addr_a, cur_addr_b;
    logic [DW-1:0] cur_word_a, cur_word_b;
    logic          word_valid_a, word_valid_b;
    logic          busy_a, busy_b;
    logic          done_a, done_b;
    logic [DW-1:0] checksum_a, checksum_b;

    logic [DW-1:0] mem [1 << AW];

    int n_checks = 0;
    int n_errors = 0;
    int en_cnt_a = 0;

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = 16'h1000 + 16'(i);
    end

    always @(posedge clk) begin
        if (mem_en_a) dout_a <= mem[mem_addr_a];
        if (mem_en_b) dout_b <= mem[mem_addr_b];
    end

    always @(negedge clk) if (mem_en_a) en_cnt_a++;

    dmem_scan_reader #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .DWELL     (0)
    ) u_dut_a (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start_a),
        .base_addr_i (base),
        .count_i     (count),
        .step_i      (step_a),
        .mem_en_o    (mem_en_a),
        .mem_addr_o  (mem_addr_a),
        .mem_dout_i  (dout_a),
        .cur_addr_o  (cur_addr_a),
        .cur_word_o  (cur_word_a),
        .word_valid_o(word_valid_a),
        .busy_o      (busy_a),
        .done_o      (done_a),
        .checksum_o  (checksum_a)
    );

    dmem_scan_reader #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .DWELL     (4)
    ) u_dut_b (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start_b),
        .base_addr_i (base),
        .count_i     (count),
        .step_i      (1'b0),
        .mem_en_o    (mem_en_b),
        .mem_addr_o  (mem_addr_b),
        .mem_dout_i  (dout_b),
        .cur_addr_o  (cur_addr_b),
        .cur_word_o  (cur_word_b),
        .word_valid_o(word_valid_b),
        .busy_o      (busy_b),
        .done_o      (done_b),
        .checksum_o  (checksum_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic pulse_start_a(input logic [AW-1:0] b, input logic [AW:0] c);
        base    = b;
        count   = c;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
    endtask

    task automatic pulse_step_a();
        step_a = 1'b1;
        @(negedge clk);
        step_a = 1'b0;
    endtask

    // Called one edge after the initiating pulse; returns edges counted from it.
    task automatic wait_valid_a(output int edges);
        edges = 1;
        while (!word_valid_a && edges < 20) begin
            @(negedge clk);
            edges++;
        end
    endtask

    task automatic count_high_b(output int n);
        n = 0;
        while (word_valid_b && n < 50) begin
            n++;
            @(negedge clk);
        end
    endtask

    // Step mode scan of base=4, count=3: shared by the plain and noisy-input runs.
    task automatic check_tail_4_3(input string t, input int lat);
        int e;
        check({t, "_lat"}, lat, 3);
        check({t, "_a0"}, cur_addr_a, 32'h004);
        check({t, "_w0"}, cur_word_a, 32'h1004);
        check({t, "_busy"}, busy_a, 1);
        pulse_step_a();
        check({t, "_gap"}, word_valid_a, 0);
        wait_valid_a(e);
        check({t, "_lat1"}, e, 3);
        check({t, "_a1"}, cur_addr_a, 32'h005);
        check({t, "_w1"}, cur_word_a, 32'h1005);
        pulse_step_a();
        wait_valid_a(e);
        check({t, "_a2"}, cur_addr_a, 32'h006);
        check({t, "_w2"}, cur_word_a, 32'h1006);
        pulse_step_a();
        check({t, "_done"}, done_a, 1);
        check({t, "_nbusy"}, busy_a, 0);
        check({t, "_nvalid"}, word_valid_a, 0);
        check({t, "_sum"}, checksum_a, 32'h300F);
        check({t, "_keep"}, cur_word_a, 32'h1006);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        int lat;
        int n;
        int en_before;

        rst     = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        step_a  = 1'b0;
        base    = '0;
        count   = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_state", 32'(u_dut_a.state_q), 32'(StIdle));
        check("rst_en", mem_en_a, 0);
        check("rst_valid", word_valid_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_sum", checksum_a, 0);

        // Test 2: plain stepped scan
        pulse_start_a(9'h004, 10'd3);
        wait_valid_a(lat);
        check_tail_4_3("t2", lat);

        // Test 3: address wrap at top of memory
        pulse_start_a(9'h1FF, 10'd2);
        check("t3_clr_done", done_a, 0);
        wait_valid_a(lat);
        check("t3_a0", cur_addr_a, 32'h1FF);
        check("t3_w0", cur_word_a, 32'h11FF);
        pulse_step_a();
        wait_valid_a(lat);
        check("t3_a1", cur_addr_a, 32'h000);
        check("t3_w1", cur_word_a, 32'h1000);
        pulse_step_a();
        check("t3_done", done_a, 1);
        check("t3_sum", checksum_a, 32'h21FF);

        // Test 4: zero-length scan
        en_before = en_cnt_a;
        pulse_start_a(9'h020, 10'd0);
        check("t4_done", done_a, 1);
        check("t4_busy", busy_a, 0);
        check("t4_sum", checksum_a, 0);
        repeat (4) @(negedge clk);
        check("t4_no_en", en_cnt_a - en_before, 0);

        // Test 5: step and start while in REQ/WAIT/HOLD must be ignored
        base    = 9'h004;
        count   = 10'd3;
        start_a = 1'b1;
        @(negedge clk);
        base   = 9'h100;
        count  = 10'd5;
        step_a = 1'b1;
        @(negedge clk);
        @(negedge clk);
        start_a = 1'b0;
        step_a  = 1'b0;
        check("t5_valid", word_valid_a, 1);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        check("t5_hold_addr", cur_addr_a, 32'h004);
        check("t5_hold_valid", word_valid_a, 1);
        check_tail_4_3("t5", 3);

        // Test 1: reset in the middle of a scan
        pulse_start_a(9'h004, 10'd3);
        wait_valid_a(lat);
        pulse_step_a();
        check("t1_pre_en", mem_en_a, 1);
        rst = 1'b1;
        @(negedge clk);
        check("t1_en_drop", mem_en_a, 0);
        @(negedge clk);
        rst = 1'b0;
        check("t1_state", 32'(u_dut_a.state_q), 32'(StIdle));
        check("t1_addr", mem_addr_a, 0);
        check("t1_cur_addr", cur_addr_a, 0);
        check("t1_cur_word", cur_word_a, 0);
        check("t1_valid", word_valid_a, 0);
        check("t1_busy", busy_a, 0);
        check("t1_done", done_a, 0);
        check("t1_sum", checksum_a, 0);
        @(negedge clk);
        check("t1_stay_idle", 32'(u_dut_a.state_q), 32'(StIdle));

        // Test 6: DWELL=4 auto-advance, no step
        base    = 9'h010;
        count   = 10'd2;
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        n = 0;
        while (!word_valid_b && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("t6_a0", cur_addr_b, 32'h010);
        check("t6_w0", cur_word_b, 32'h1010);
        count_high_b(n);
        check("t6_dwell0", n, 4);
        n = 0;
        while (!word_valid_b && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("t6_a1", cur_addr_b, 32'h011);
        check("t6_w1", cur_word_b, 32'h1011);
        count_high_b(n);
        check("t6_dwell1", n, 4);
        check("t6_done", done_b, 1);
        check("t6_sum", checksum_b, 32'h2021);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
